param_queue: RTL and testbench
==============================

PARAM_QUEUE -- requirements
Module: param_queue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning payload bits per entry (legal range 1..512).
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning entry count (legal range 1..64; non-power-of-two allowed).
REQ-003 The block SHALL have parameter PIPE, default 0, meaning that when 1, a full queue accepts an enqueue in the same cycle as a dequeue.
REQ-004 The block SHALL have parameter FLOW, default 0, meaning that when 1, an empty queue passes enq data combinationally to deq.
REQ-005 The block SHALL have parameter AF_LEVEL, default DEPTH-1, meaning the almost-full threshold (legal range 1..DEPTH).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port io_enq_valid, input, 1 bit: producer offers io_enq_bits.
REQ-009 The block SHALL have port io_enq_ready, output, 1 bit: the queue accepts this cycle.
REQ-010 The block SHALL have port io_enq_bits, input, WIDTH bits: the enqueue payload.
REQ-011 The block SHALL have port io_deq_valid, output, 1 bit: io_deq_bits is valid.
REQ-012 The block SHALL have port io_deq_ready, input, 1 bit: the consumer takes the head this cycle.
REQ-013 The block SHALL have port io_deq_bits, output, WIDTH bits: the head payload.
REQ-014 The block SHALL have port io_count, output, CW = clog2(DEPTH+1) bits: the occupancy.
REQ-015 The block SHALL have port io_almost_full, output, 1 bit: io_count >= AF_LEVEL.

Function
REQ-016 Storage SHALL be a DEPTH-entry array with enq_ptr/deq_ptr of max(1,clog2(DEPTH)) bits plus a maybe_full flag; empty = ptr_match & !maybe_full, full = ptr_match & maybe_full.
REQ-017 Each pointer SHALL wrap from DEPTH-1 to 0 (explicit compare, not natural overflow, for non-power-of-two DEPTH); for DEPTH=1 the pointers SHALL be constant 0.
REQ-018 Signal do_enq SHALL equal io_enq_valid & io_enq_ready, and do_deq SHALL equal io_deq_valid & io_deq_ready; do_enq writes io_enq_bits at enq_ptr on the next clk edge.
REQ-019 The maybe_full flag SHALL update to do_enq only when do_enq != do_deq, and SHALL otherwise hold.
REQ-020 With PIPE=0, io_enq_ready SHALL be !full; with PIPE=1, it SHALL be !full | io_deq_ready.
REQ-021 With FLOW=0, io_deq_valid SHALL be !empty; with FLOW=1, it SHALL be !empty | io_enq_valid.
REQ-022 When FLOW=1, the queue is empty, and io_enq_valid is high, io_deq_bits SHALL equal io_enq_bits; if io_deq_ready is also high, nothing SHALL be written and no pointer or flag SHALL change.
REQ-023 In every other case, io_deq_bits SHALL be ram[deq_ptr] with zero read latency; enqueue-to-dequeue latency SHALL be 1 cycle (0 in FLOW bypass).
REQ-024 A simultaneous enqueue and dequeue SHALL advance both pointers and leave io_count unchanged, including when full under PIPE=1.
REQ-025 io_count SHALL be DEPTH when full, otherwise (enq_ptr - deq_ptr) mod DEPTH, computed in CW bits with no truncation at DEPTH = 2^k.
REQ-026 io_count and io_almost_full SHALL depend only on registered state and SHALL NOT reflect the FLOW bypass.

Reset
REQ-027 Asserting reset SHALL immediately clear enq_ptr, deq_ptr and maybe_full, giving io_deq_valid=0 (FLOW=0), io_enq_ready=1, io_count=0 and io_almost_full=0.
REQ-028 Storage contents SHALL NOT be reset; an enqueue in flight when reset asserts SHALL be discarded.
REQ-029 Deassertion of reset SHALL be externally synchronised to clk; the first enqueue SHALL be accepted on the first edge after deassertion.

Structure
REQ-030 The helper function for clog2 and the pointer-increment-with-wrap function SHALL reside in the shared queue package, reused by all queue variants.
REQ-031 The block SHALL be a single module with no sub-module; storage SHALL be inferable as distributed RAM (no reset, one write port, one asynchronous read port).

Verification
REQ-032 Directed test: DEPTH=4, PIPE=0, FLOW=0; enqueue 0x11,0x22,0x33,0x44 with deq_ready=0 -> io_count reaches 4, io_enq_ready=0, io_almost_full=1 from count 3; drain -> data returns in order and io_count returns to 0.
REQ-033 Directed test: DEPTH=3; run 10 enqueue/dequeue pairs -> pointers wrap 2->0, data returns in order, io_count never exceeds 3.
REQ-034 Directed test: DEPTH=2, PIPE=1, full, enq_valid=1, deq_ready=1 -> io_enq_ready=1, both transfers occur, io_count stays 2.
REQ-035 Directed test: DEPTH=2, FLOW=1, empty, enq 0xAB with deq_ready=1 -> io_deq_valid=1 and io_deq_bits=0xAB in the same cycle; io_count stays 0.
REQ-036 Directed test: DEPTH=1, defaults -> behaves as a single-entry queue: io_count alternates 0/1 and io_enq_ready = !io_deq_valid.
REQ-037 Directed test: with 3 entries held, assert reset mid-cycle (asynchronously) -> io_count=0 and io_deq_valid=0 before the next edge; the following enqueue of 0x5 dequeues as 0x5.

Source files
------------

// File: rtl/param_queue_pkg.sv
// Shared helpers for the queue family: width math and wrap-around pointer
// stepping used by every queue variant.
package param_queue_pkg;

  // Ceiling log2; clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = unsigned'(i) + 1;
      end
    end
    return result;
  endfunction

  // Pointer width: at least one bit so a DEPTH=1 queue still has a legal pointer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

  // Step a pointer, wrapping from depth-1 back to 0 with an explicit compare so
  // non-power-of-two depths never land on an unused slot. depth=1 always yields 0.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/param_queue.sv
// Parameterised ready/valid queue: DEPTH-entry circular buffer with optional
// pipelined enqueue when full (PIPE) and combinational empty bypass (FLOW).
module param_queue
  import param_queue_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned PIPE     = 0,
  parameter int unsigned FLOW     = 0,
  parameter int unsigned AF_LEVEL = DEPTH - 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          io_enq_valid,
  output logic                          io_enq_ready,
  input  logic [WIDTH-1:0]              io_enq_bits,
  output logic                          io_deq_valid,
  input  logic                          io_deq_ready,
  output logic [WIDTH-1:0]              io_deq_bits,
  output logic [clog2(DEPTH+1)-1:0]     io_count,
  output logic                          io_almost_full
);

  localparam int unsigned CW     = clog2(DEPTH + 1);
  localparam int unsigned PW     = ptr_width(DEPTH);
  localparam bit          PipeEn = (PIPE != 0);
  localparam bit          FlowEn = (FLOW != 0);

  // Storage carries no reset so it maps onto distributed RAM.
  logic [WIDTH-1:0] r_ram [DEPTH];

  logic [PW-1:0] r_enq_ptr;
  logic [PW-1:0] r_deq_ptr;
  logic          r_maybe_full;

  logic          w_ptr_match;
  logic          w_empty;
  logic          w_full;
  logic          w_bypass;
  logic          w_pass_thru;
  logic          w_do_enq;
  logic          w_do_deq;
  logic          w_enq_fire;
  logic          w_deq_fire;
  logic [PW-1:0] w_enq_ptr_nxt;
  logic [PW-1:0] w_deq_ptr_nxt;
  logic [CW-1:0] w_count;

  assign w_ptr_match = (r_enq_ptr == r_deq_ptr);
  assign w_empty     = w_ptr_match & ~r_maybe_full;
  assign w_full      = w_ptr_match & r_maybe_full;

  assign io_enq_ready = ~w_full | (PipeEn & io_deq_ready);
  assign io_deq_valid = ~w_empty | (FlowEn & io_enq_valid);

  // Empty FLOW queue forwards the producer straight to the consumer.
  assign w_bypass    = FlowEn & w_empty & io_enq_valid;
  // A bypassed beat that is also consumed never touches storage or pointers.
  assign w_pass_thru = w_bypass & io_deq_ready;

  assign w_do_enq   = io_enq_valid & io_enq_ready;
  assign w_do_deq   = io_deq_valid & io_deq_ready;
  assign w_enq_fire = w_do_enq & ~w_pass_thru;
  assign w_deq_fire = w_do_deq & ~w_pass_thru;

  assign w_enq_ptr_nxt = PW'(ptr_inc(32'(r_enq_ptr), DEPTH));
  assign w_deq_ptr_nxt = PW'(ptr_inc(32'(r_deq_ptr), DEPTH));

  assign io_deq_bits = w_bypass ? io_enq_bits : r_ram[r_deq_ptr];

  // Pointer and full-flag state; cleared immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enq_ptr    <= '0;
      r_deq_ptr    <= '0;
      r_maybe_full <= 1'b0;
    end else begin
      if (w_enq_fire) begin
        r_enq_ptr <= w_enq_ptr_nxt;
      end
      if (w_deq_fire) begin
        r_deq_ptr <= w_deq_ptr_nxt;
      end
      if (w_enq_fire != w_deq_fire) begin
        r_maybe_full <= w_enq_fire;
      end
    end
  end

  // Single write port into the payload array.
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_ram[r_enq_ptr] <= io_enq_bits;
    end
  end

  // Occupancy from registered state only; widened to CW bits before the
  // subtraction so DEPTH = 2^k does not truncate.
  always_comb begin
    w_count = '0;
    if (w_full) begin
      w_count = CW'(DEPTH);
    end else if (r_enq_ptr >= r_deq_ptr) begin
      w_count = CW'(r_enq_ptr) - CW'(r_deq_ptr);
    end else begin
      w_count = CW'(DEPTH) + CW'(r_enq_ptr) - CW'(r_deq_ptr);
    end
  end

  assign io_count       = w_count;
  assign io_almost_full = (32'(w_count) >= AF_LEVEL);

endmodule

// File: tb/tb_param_queue.sv
// Bench for param_queue: five configurations side by side, a directed vector
// table, hand sequences for wrap and async reset, and randomized traffic
// checked against a queue-based reference model.
module tb_param_queue;

  localparam int NDUT = 5;
  localparam int W    = 8;

  // Configurations: 0: D4, 1: D3, 2: D2 PIPE, 3: D2 FLOW, 4: D1.
  function automatic int dep_of(input int g);
    if (g == 0) return 4;
    if (g == 1) return 3;
    if (g == 2 || g == 3) return 2;
    return 1;
  endfunction
  function automatic int pipe_of(input int g);
    return (g == 2) ? 1 : 0;
  endfunction
  function automatic int flow_of(input int g);
    return (g == 3) ? 1 : 0;
  endfunction
  function automatic int af_of(input int g);
    return (dep_of(g) > 1) ? dep_of(g) - 1 : 1;
  endfunction

  logic         clk = 1'b0;
  logic         reset;
  logic         ev  [NDUT];
  logic         dr  [NDUT];
  logic [W-1:0] eb  [NDUT];
  logic         er  [NDUT];
  logic         dv  [NDUT];
  logic         af  [NDUT];
  logic [W-1:0] db  [NDUT];
  logic [3:0]   cnt [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int CW = $clog2(dep_of(g) + 1);
    logic [CW-1:0] count;
    param_queue #(
      .WIDTH   (W),
      .DEPTH   (dep_of(g)),
      .PIPE    (pipe_of(g)),
      .FLOW    (flow_of(g)),
      .AF_LEVEL(af_of(g))
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .io_enq_valid  (ev[g]),
      .io_enq_ready  (er[g]),
      .io_enq_bits   (eb[g]),
      .io_deq_valid  (dv[g]),
      .io_deq_ready  (dr[g]),
      .io_deq_bits   (db[g]),
      .io_count      (count),
      .io_almost_full(af[g])
    );
    assign cnt[g] = 4'(count);
  end

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int g, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, g, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    for (int g = 0; g < NDUT; g++) begin
      ev[g] = 1'b0;
      dr[g] = 1'b0;
      eb[g] = '0;
    end
  endtask

  // Directed vectors with hand-derived expectations.
  typedef struct {
    int         g;
    bit         ev;
    logic [7:0] eb;
    bit         dr;
    bit         x_er;
    bit         x_dv;
    logic [7:0] x_db;
    int         x_cnt;
    bit         x_af;
  } vec_t;

  vec_t tbl[$];

  task automatic apply_vec(input vec_t v);
    clear_inputs();
    ev[v.g] = v.ev;
    eb[v.g] = v.eb;
    dr[v.g] = v.dr;
    #2;
    chk("tbl_enq_ready", v.g, int'(er[v.g]), int'(v.x_er));
    chk("tbl_deq_valid", v.g, int'(dv[v.g]), int'(v.x_dv));
    if (v.x_dv) chk("tbl_deq_bits", v.g, int'(db[v.g]), int'(v.x_db));
    chk("tbl_count", v.g, int'(cnt[v.g]), v.x_cnt);
    chk("tbl_almost_full", v.g, int'(af[v.g]), int'(v.x_af));
    @(posedge clk);
    #1;
  endtask

  // Reference model: one plain FIFO of payloads per configuration.
  logic [W-1:0] mq [NDUT][$];

  task automatic model_cycle();
    bit de [NDUT];
    bit dd [NDUT];
    #2;
    for (int g = 0; g < NDUT; g++) begin
      int n;
      bit full, empty, x_er, x_dv, byp;
      n     = mq[g].size();
      full  = (n == dep_of(g));
      empty = (n == 0);
      x_er  = !full || (pipe_of(g) == 1 && dr[g]);
      x_dv  = !empty || (flow_of(g) == 1 && ev[g]);
      chk("mdl_enq_ready", g, int'(er[g]), int'(x_er));
      chk("mdl_deq_valid", g, int'(dv[g]), int'(x_dv));
      if (x_dv) chk("mdl_deq_bits", g, int'(db[g]), empty ? int'(eb[g]) : int'(mq[g][0]));
      chk("mdl_count", g, int'(cnt[g]), n);
      chk("mdl_almost_full", g, int'(af[g]), (n >= af_of(g)) ? 1 : 0);
      byp   = empty && flow_of(g) == 1 && ev[g] && dr[g];
      de[g] = ev[g] && x_er && !byp;
      dd[g] = x_dv && dr[g] && !byp;
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      if (dd[g]) void'(mq[g].pop_front());
      if (de[g]) mq[g].push_back(eb[g]);
    end
  endtask

  task automatic clear_model();
    for (int g = 0; g < NDUT; g++) mq[g].delete();
  endtask

  task automatic do_reset();
    clear_inputs();
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    for (int g = 0; g < NDUT; g++) begin
      chk("rst_count", g, int'(cnt[g]), 0);
      chk("rst_enq_ready", g, int'(er[g]), 1);
      chk("rst_deq_valid", g, int'(dv[g]), 0);
      chk("rst_almost_full", g, int'(af[g]), 0);
    end
    @(posedge clk);
    #1;

    //             g ev  eb     dr er dv db     cnt af
    // DEPTH=4: fill to full, then drain in order
    tbl.push_back(vec_t'{0, 1, 8'h11, 0, 1, 0, 8'h00, 0, 0});
    tbl.push_back(vec_t'{0, 1, 8'h22, 0, 1, 1, 8'h11, 1, 0});
    tbl.push_back(vec_t'{0, 1, 8'h33, 0, 1, 1, 8'h11, 2, 0});
    tbl.push_back(vec_t'{0, 1, 8'h44, 0, 1, 1, 8'h11, 3, 1});
    tbl.push_back(vec_t'{0, 1, 8'h55, 0, 0, 1, 8'h11, 4, 1});
    tbl.push_back(vec_t'{0, 0, 8'h00, 1, 0, 1, 8'h11, 4, 1});
    tbl.push_back(vec_t'{0, 0, 8'h00, 1, 1, 1, 8'h22, 3, 1});
    tbl.push_back(vec_t'{0, 0, 8'h00, 1, 1, 1, 8'h33, 2, 0});
    tbl.push_back(vec_t'{0, 0, 8'h00, 1, 1, 1, 8'h44, 1, 0});
    tbl.push_back(vec_t'{0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0});
    // DEPTH=2 PIPE: simultaneous enq/deq while full
    tbl.push_back(vec_t'{2, 1, 8'haa, 0, 1, 0, 8'h00, 0, 0});
    tbl.push_back(vec_t'{2, 1, 8'hbb, 0, 1, 1, 8'haa, 1, 1});
    tbl.push_back(vec_t'{2, 1, 8'hcc, 0, 0, 1, 8'haa, 2, 1});
    tbl.push_back(vec_t'{2, 1, 8'hcc, 1, 1, 1, 8'haa, 2, 1});
    tbl.push_back(vec_t'{2, 0, 8'h00, 0, 0, 1, 8'hbb, 2, 1});
    tbl.push_back(vec_t'{2, 0, 8'h00, 1, 1, 1, 8'hbb, 2, 1});
    tbl.push_back(vec_t'{2, 0, 8'h00, 1, 1, 1, 8'hcc, 1, 1});
    tbl.push_back(vec_t'{2, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0});
    // DEPTH=2 FLOW: bypass when consumed, store when not
    tbl.push_back(vec_t'{3, 1, 8'hab, 1, 1, 1, 8'hab, 0, 0});
    tbl.push_back(vec_t'{3, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0});
    tbl.push_back(vec_t'{3, 1, 8'hcd, 0, 1, 1, 8'hcd, 0, 0});
    tbl.push_back(vec_t'{3, 0, 8'h00, 0, 1, 1, 8'hcd, 1, 1});
    tbl.push_back(vec_t'{3, 0, 8'h00, 1, 1, 1, 8'hcd, 1, 1});
    tbl.push_back(vec_t'{3, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0});
    // DEPTH=1: enq_ready mirrors !deq_valid
    tbl.push_back(vec_t'{4, 1, 8'h05, 0, 1, 0, 8'h00, 0, 0});
    tbl.push_back(vec_t'{4, 1, 8'h06, 0, 0, 1, 8'h05, 1, 1});
    tbl.push_back(vec_t'{4, 0, 8'h00, 1, 0, 1, 8'h05, 1, 1});
    tbl.push_back(vec_t'{4, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0});
    tbl.push_back(vec_t'{4, 1, 8'h07, 0, 1, 0, 8'h00, 0, 0});
    tbl.push_back(vec_t'{4, 0, 8'h00, 0, 0, 1, 8'h07, 1, 1});
    tbl.push_back(vec_t'{4, 0, 8'h00, 1, 0, 1, 8'h07, 1, 1});
    tbl.push_back(vec_t'{4, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0});
    foreach (tbl[i]) apply_vec(tbl[i]);

    // DEPTH=3: streaming pairs, pointers wrap several times
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      clear_inputs();
      ev[1] = (i < 10);
      eb[1] = 8'(i * 17 + 3);
      dr[1] = (i > 0);
      model_cycle();
      chk("wrap_count_le3", 1, (cnt[1] <= 4'd3) ? 1 : 0, 1);
    end
    // DEPTH=3: fill, then drain across the wrap point
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      ev[1] = (i < 4);
      eb[1] = 8'(8'h90 + i);
      dr[1] = (i >= 4);
      model_cycle();
    end

    // Randomized traffic on every configuration at once
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int g = 0; g < NDUT; g++) begin
        ev[g] = ($urandom_range(0, 3) != 0);
        dr[g] = ($urandom_range(0, 2) != 0);
        eb[g] = 8'($urandom);
      end
      if (n % 50 < 10) begin
        for (int g = 0; g < NDUT; g++) dr[g] = 1'b0;
      end
      model_cycle();
    end

    // Async reset mid-cycle with 3 entries held and an enqueue in flight
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      ev[0] = 1'b1;
      eb[0] = 8'(8'h60 + i);
      model_cycle();
    end
    clear_inputs();
    ev[0] = 1'b1;
    eb[0] = 8'h77;
    #3;
    chk("pre_rst_count", 0, int'(cnt[0]), 3);
    reset = 1'b1;
    #1;
    chk("async_rst_count", 0, int'(cnt[0]), 0);
    chk("async_rst_deq_valid", 0, int'(dv[0]), 0);
    chk("async_rst_enq_ready", 0, int'(er[0]), 1);
    chk("async_rst_almost_full", 0, int'(af[0]), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
    clear_inputs();
    ev[0] = 1'b1;
    eb[0] = 8'h05;
    model_cycle();
    clear_inputs();
    dr[0] = 1'b1;
    #2;
    chk("post_rst_deq_bits", 0, int'(db[0]), 8'h05);
    chk("post_rst_count", 0, int'(cnt[0]), 1);
    @(posedge clk);
    #1;
    clear_inputs();
    #2;
    chk("post_rst_drained", 0, int'(cnt[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
